multimode_ff_bank: RTL and testbench

//   WIDTH-bit bank of flip-flops that switches between D, T, SR and JK

---
 rtl/multimode_ff_bank.sv | 52 +++++
 tb/tb_multimode_ff_bank.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/multimode_ff_bank.sv
// multimode_ff_bank: WIDTH-lane D/T/SR/JK flip-flop bank with sticky SR 1/1 error logging
module multimode_ff_bank #(
    parameter int WIDTH     = 8,
    parameter int ERR_CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qn,
    output logic                 sr_err,
    output logic [WIDTH-1:0]     err_bits,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    logic [WIDTH-1:0]     hit, q_sr, q_jk, q_nxt, bits_base, bits_nxt;
    logic [ERR_CNT_W-1:0] cnt_base, cnt_nxt;
    logic                 ev, err_nxt;

    // SR 1/1 holds like 0/0; the clear is applied before the event is folded in
    always_comb begin
        hit       = a & b;
        ev        = en && mode == 2'b10 && |hit;
        q_sr      = (q & ~(b & ~a)) | (a & ~b);
        q_jk      = (q & ~b) | (~q & a);
        q_nxt     = !en ? q : mode == 2'b00 ? a : mode == 2'b01 ? q ^ a : mode == 2'b10 ? q_sr : q_jk;
        bits_base = clr_err ? '0 : err_bits;
        cnt_base  = clr_err ? '0 : err_cnt;
        bits_nxt  = ev ? bits_base | hit : bits_base;
        cnt_nxt   = ev && !(&cnt_base) ? cnt_base + 1'b1 : cnt_base;
        err_nxt   = ev || (!clr_err && sr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q        <= '0;
            sr_err   <= 1'b0;
            err_bits <= '0;
            err_cnt  <= '0;
        end else begin
            q        <= q_nxt;
            sr_err   <= err_nxt;
            err_bits <= bits_nxt;
            err_cnt  <= cnt_nxt;
        end
    end

    assign qn = ~q;
endmodule

// File: tb/tb_multimode_ff_bank.sv
// tb_multimode_ff_bank: directed checks of the multimode flip-flop bank
module tb_multimode_ff_bank;
    logic       clk = 1'b0;
    logic       rst_n, en, clr_err;
    logic [1:0] mode;
    logic [7:0] a, b, q, qn, err_bits;
    logic       sr_err;
    logic [3:0] err_cnt;
    int         tests = 0;
    int         fails = 0;

    multimode_ff_bank #(.WIDTH(8), .ERR_CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a), .b(b), .clr_err(clr_err),
        .q(q), .qn(qn), .sr_err(sr_err), .err_bits(err_bits), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic e, input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv, input logic c);
        en = e; mode = m; a = av; b = bv; clr_err = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        #2;
        tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_init_q: got %h want 00", q); end
        tests++; if (qn !== 8'hFF) begin fails++; $display("FAIL reset_init_qn: got %h want ff", qn); end
        tick();
        rst_n = 1'b1;
        drive(1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0);
        tick();
        drive(1'b1, 2'b00, 8'hA5, 8'h00, 1'b0);
        tick();
        tests++; if (q !== 8'hA5 || sr_err !== 1'b1) begin fails++; $display("FAIL reset_pre: got q=%h err=%b want a5 1", q, sr_err); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (q !== 8'h00) begin fails++; $display("FAIL reset_async_q: got %h want 00", q); end
        tests++; if (qn !== 8'hFF) begin fails++; $display("FAIL reset_async_qn: got %h want ff", qn); end
        tests++; if (sr_err !== 1'b0 || err_bits !== 8'h00 || err_cnt !== 4'h0) begin
            fails++; $display("FAIL reset_async_err: got %b %h %h want 0 00 0", sr_err, err_bits, err_cnt);
        end
        drive(1'b1, 2'b10, 8'hFF, 8'hFF, 1'b1);
        tick();
        tests++; if (q !== 8'h00 || sr_err !== 1'b0 || err_cnt !== 4'h0) begin
            fails++; $display("FAIL reset_overrides: got q=%h err=%b cnt=%h want 00 0 0", q, sr_err, err_cnt);
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        #2 rst_n = 1'b1;
    endtask

    task automatic test_d_t();
        drive(1'b1, 2'b00, 8'hA5, 8'h00, 1'b0);
        tick();
        tests++; if (q !== 8'hA5) begin fails++; $display("FAIL d_q: got %h want a5", q); end
        tests++; if (qn !== 8'h5A) begin fails++; $display("FAIL d_qn: got %h want 5a", qn); end
        drive(1'b1, 2'b01, 8'h0F, 8'hFF, 1'b0);
        tick();
        tests++; if (q !== 8'hAA) begin fails++; $display("FAIL t_first: got %h want aa", q); end
        tick();
        tests++; if (q !== 8'hA5) begin fails++; $display("FAIL t_second: got %h want a5", q); end
    endtask

    task automatic test_sr_jk();
        drive(1'b1, 2'b00, 8'hF0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 2'b10, 8'h0F, 8'h00, 1'b0);
        tick();
        tests++; if (q !== 8'hFF) begin fails++; $display("FAIL sr_set: got %h want ff", q); end
        drive(1'b1, 2'b10, 8'h00, 8'hFF, 1'b0);
        tick();
        tests++; if (q !== 8'h00) begin fails++; $display("FAIL sr_reset: got %h want 00", q); end
        drive(1'b1, 2'b11, 8'hFF, 8'hFF, 1'b0);
        tick();
        tests++; if (q !== 8'hFF) begin fails++; $display("FAIL jk_toggle: got %h want ff", q); end
        drive(1'b1, 2'b11, 8'h00, 8'h00, 1'b0);
        tick();
        tests++; if (q !== 8'hFF) begin fails++; $display("FAIL jk_hold: got %h want ff", q); end
        drive(1'b1, 2'b11, 8'h0F, 8'hF0, 1'b0);
        tick();
        tests++; if (q !== 8'h0F) begin fails++; $display("FAIL jk_set_reset: got %h want 0f", q); end
        tests++; if (sr_err !== 1'b0 || err_cnt !== 4'h0) begin
            fails++; $display("FAIL jk_no_err: got %b %h want 0 0", sr_err, err_cnt);
        end
    endtask

    task automatic test_sr_err();
        drive(1'b1, 2'b00, 8'h3C, 8'h00, 1'b0);
        tick();
        drive(1'b1, 2'b10, 8'h81, 8'h01, 1'b0);
        tick();
        tests++; if (q !== 8'hBC) begin fails++; $display("FAIL sr_err1_q: got %h want bc", q); end
        tests++; if (sr_err !== 1'b1 || err_bits !== 8'h01 || err_cnt !== 4'h1) begin
            fails++; $display("FAIL sr_err1_state: got %b %h %h want 1 01 1", sr_err, err_bits, err_cnt);
        end
        drive(1'b1, 2'b10, 8'hC0, 8'hC0, 1'b0);
        tick();
        tests++; if (q !== 8'hBC) begin fails++; $display("FAIL sr_err2_q: got %h want bc", q); end
        tests++; if (sr_err !== 1'b1 || err_bits !== 8'hC1 || err_cnt !== 4'h2) begin
            fails++; $display("FAIL sr_err2_state: got %b %h %h want 1 c1 2", sr_err, err_bits, err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 4) begin
                tests++; if (err_cnt !== 4'h7) begin fails++; $display("FAIL cnt_mid: got %h want 7", err_cnt); end
            end
        end
        tests++; if (err_cnt !== 4'hF) begin fails++; $display("FAIL cnt_sat: got %h want f", err_cnt); end
        tests++; if (err_bits !== 8'hFF || q !== 8'hBC) begin
            fails++; $display("FAIL sat_bits_q: got %h %h want ff bc", err_bits, q);
        end
        drive(1'b1, 2'b10, 8'h02, 8'h02, 1'b1);
        tick();
        tests++; if (sr_err !== 1'b1 || err_bits !== 8'h02 || err_cnt !== 4'h1) begin
            fails++; $display("FAIL clr_with_event: got %b %h %h want 1 02 1", sr_err, err_bits, err_cnt);
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b1);
        tick();
        tests++; if (sr_err !== 1'b0 || err_bits !== 8'h00 || err_cnt !== 4'h0) begin
            fails++; $display("FAIL clr_alone: got %b %h %h want 0 00 0", sr_err, err_bits, err_cnt);
        end
        tests++; if (q !== 8'hBC) begin fails++; $display("FAIL clr_keeps_q: got %h want bc", q); end
    endtask

    task automatic test_en_hold();
        drive(1'b1, 2'b10, 8'h01, 8'h01, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'b10, 8'hFF, 8'hFF, 1'b0);
            tick();
            tests++; if (q !== 8'hBC) begin fails++; $display("FAIL en0_q[%0d]: got %h want bc", i, q); end
            tests++; if (sr_err !== 1'b1 || err_bits !== 8'h01 || err_cnt !== 4'h1) begin
                fails++; $display("FAIL en0_err[%0d]: got %b %h %h want 1 01 1", i, sr_err, err_bits, err_cnt);
            end
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
        tick();
        tests++; if (q !== 8'hBC) begin fails++; $display("FAIL en0_d: got %h want bc", q); end
        drive(1'b0, 2'b01, 8'hFF, 8'h00, 1'b0);
        tick();
        tests++; if (q !== 8'hBC) begin fails++; $display("FAIL en0_t: got %h want bc", q); end
    endtask

    initial begin
        test_reset();
        test_d_t();
        test_sr_jk();
        test_sr_err();
        test_back_to_back();
        test_en_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
